// File: rtl/bcd_excess3_sequencer.sv
// Sequences a packed BCD word one digit at a time through an external shared
// BCD-to-Excess-3 converter and repacks the results, flagging any digit above 9.
module bcd_excess3_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_word,
    output logic [3:0]            conv_bcd,
    input  logic [3:0]            conv_xs3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   xs3_word,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] cap_word;
    logic [3:0]          cur_digit;
    logic                digit_bad;
    logic                accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)                 state_next = CONV;
            CONV: if (idx == LAST_IDX)        state_next = DONE;
            DONE: if (out_ready)              state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = (state == IDLE) && in_valid;
        conv_bcd  = (state == CONV) ? cur_digit : 4'b0000;
    end

    // Digit selected by idx from the captured word; feeds the converter and range check.
    always_comb begin
        cur_digit = 4'b0000;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = cap_word[i*4 +: 4];
            end
        end
        digit_bad = (cur_digit > 4'd9);
    end

    // Datapath: capture on accept, then fill one result slot per CONV cycle.
    // idx saturates on the last digit so it never wraps inside a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            cap_word <= '0;
            xs3_word <= '0;
            err_mask <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            idx      <= '0;
            cap_word <= bcd_word;
            xs3_word <= '0;
            err_mask <= '0;
            err      <= 1'b0;
        end else if (state == CONV) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IDX_W'(i)) begin
                    xs3_word[i*4 +: 4] <= digit_bad ? 4'b0000 : conv_xs3;
                    if (digit_bad) begin
                        err_mask[i] <= 1'b1;
                    end
                end
            end
            err <= err | digit_bad;
            if (idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_excess3_sequencer.sv
// Self-checking bench for bcd_excess3_sequencer with an ideal xs3 = bcd + 3 converter,
// comparing against a digit-wise arithmetic reference model.
module tb_bcd_excess3_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_word;
    logic [3:0]  conv_bcd;
    logic [3:0]  conv_xs3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xs3_word;
    logic [3:0]  err_mask;
    logic        err;

    int checks = 0;
    int fails  = 0;
    int cycle_count = 0;
    int last_accept = 0;
    bit have_last_accept = 1'b0;

    bcd_excess3_sequencer #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_word  (bcd_word),
        .conv_bcd  (conv_bcd),
        .conv_xs3  (conv_xs3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xs3_word  (xs3_word),
        .err_mask  (err_mask),
        .err       (err)
    );

    assign conv_xs3 = conv_bcd + 4'd3;

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: each digit <=9 maps to digit+3, otherwise 0 with its error bit set.
    function automatic void modelWord(input logic [15:0] w, output logic [15:0] x, output logic [3:0] m);
        int d;
        x = '0;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            d = int'((w >> (4 * i)) & 16'hF);
            if (d <= 9) x = x | 16'((d + 3) << (4 * i));
            else        m[i] = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] randomWord();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) != 0) w = w | 16'($urandom_range(0, 9) << (4 * i));
            else                           w = w | 16'($urandom_range(0, 15) << (4 * i));
        end
        return w;
    endfunction

    // One full word: accept, four converter cycles, optional DONE stall, handshake.
    task automatic applyStimulus(input logic [15:0] word, input int hold, input bit streaming);
        logic [15:0] exp_x;
        logic [3:0]  exp_m;
        modelWord(word, exp_x, exp_m);
        in_valid  = 1'b1;
        bcd_word  = word;
        out_ready = streaming;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        tick();
        if (streaming) begin
            if (have_last_accept) checkOutput("accept_period", 32'(cycle_count - last_accept), 32'd6);
            last_accept = cycle_count;
            have_last_accept = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            bcd_word = 16'($urandom);
            checkOutput("conv_bcd", 32'(conv_bcd), 32'((word >> (4 * i)) & 16'hF));
            checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
            checkOutput("busy_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        checkOutput("done_out_valid", 32'(out_valid), 32'd1);
        checkOutput("xs3_word", 32'(xs3_word), 32'(exp_x));
        checkOutput("err_mask", 32'(err_mask), 32'(exp_m));
        checkOutput("err", 32'(err), 32'(|exp_m));
        checkOutput("done_conv_bcd", 32'(conv_bcd), 32'd0);
        checkOutput("done_in_ready", 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            bcd_word = 16'($urandom);
            tick();
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_xs3_word", 32'(xs3_word), 32'(exp_x));
            checkOutput("stall_err_mask", 32'(err_mask), 32'(exp_m));
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("post_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_xs3_word", 32'(xs3_word), 32'(exp_x));
        checkOutput("post_err_mask", 32'(err_mask), 32'(exp_m));
        if (!streaming) out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_word  = 16'h0000;
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_xs3_word", 32'(xs3_word), 32'd0);
        checkOutput("rst_err_mask", 32'(err_mask), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_conv_bcd", 32'(conv_bcd), 32'd0);
        rst_n = 1'b1;

        $display("[TB] directed words");
        applyStimulus(16'h1234, 0, 1'b0);
        applyStimulus(16'h0909, 0, 1'b0);
        applyStimulus(16'h9A05, 0, 1'b0);
        applyStimulus(16'h5678, 3, 1'b0);
        applyStimulus(16'h2468, 0, 1'b0);

        $display("[TB] reset mid-conversion");
        in_valid = 1'b1;
        bcd_word = 16'h1234;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("mid_conv_bcd", 32'(conv_bcd), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_conv_bcd", 32'(conv_bcd), 32'd0);
        checkOutput("async_in_ready", 32'(in_ready), 32'd1);
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_xs3_word", 32'(xs3_word), 32'd0);
        checkOutput("async_err_mask", 32'(err_mask), 32'd0);
        checkOutput("async_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput("no_stale_out_valid", 32'(out_valid), 32'd0);
        end
        applyStimulus(16'h0000, 0, 1'b0);

        $display("[TB] random words");
        for (int n = 0; n < 10; n++) begin
            applyStimulus(randomWord(), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("[TB] back-to-back stream");
        have_last_accept = 1'b0;
        applyStimulus(16'h1234, 0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(randomWord(), 0, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
